// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 types, round count, S-box table and xtime helper.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_128;
    typedef logic [31:0]  aes_word;
    typedef logic [7:0]   aes_byte;

    localparam int NR = 10;

    // Row-major S-box; entry 0x00 occupies the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic aes_byte sbox_lookup(input aes_byte value);
        int top_bit;
        top_bit = 2047 - 8 * int'(value);
        return c_sbox[top_bit -: 8];
    endfunction

    function automatic aes_byte xtime(input aes_byte value);
        return {value[6:0], 1'b0} ^ (value[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_if
// Purpose  : Start/key handshake and round-key read port of the key expander.
// Revision : 1.0
// ============================================================================
interface aes_key_expand_if;
    import aes_pkg::*;

    logic       start_i;
    aes_128     key_i;
    logic       busy_o;
    logic       key_ready_o;
    logic [3:0] rd_idx_i;
    aes_128     round_key_o;
    aes_byte    r_con_o;

    modport master (
        output start_i, key_i, rd_idx_i,
        input  busy_o, key_ready_o, round_key_o, r_con_o
    );

    modport slave (
        input  start_i, key_i, rd_idx_i,
        output busy_o, key_ready_o, round_key_o, r_con_o
    );

endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : Combinational AES forward S-box, one byte in, one byte out.
// Revision : 1.0
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte value,
    output aes_byte subst
);

    assign subst = sbox_lookup(value);

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand
// Purpose  : AES-128 key schedule, one round key per clock into an 11-entry bank.
// Revision : 1.0
// ============================================================================
module aes_key_expand #(
    parameter int NR = aes_pkg::NR
) (
    input  wire logic          clk,
    input  wire logic          nrst,
    aes_key_expand_if.slave    bus
);
    import aes_pkg::*;

    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_expand = 1'b1;
    localparam logic [3:0] c_last   = 4'(NR);

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [3:0] r_rnd;
    aes_byte    r_rcon;
    logic       r_ready;
    aes_128     r_bank [0:NR];

    aes_128     w_prev;
    aes_word    w_rot;
    aes_word    w_sub;
    aes_word    w_t;
    aes_word    w_n0;
    aes_word    w_n1;
    aes_word    w_n2;
    aes_word    w_n3;
    logic       w_accept;

    assign w_accept = (r_state == c_idle) && bus.start_i;

    // Guard the bank index so idle/after-done values of r_rnd never reach it.
    assign w_prev = (r_rnd != 4'd0 && r_rnd <= c_last) ? r_bank[r_rnd - 4'd1] : '0;
    assign w_rot  = {w_prev[23:0], w_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .value (w_rot[8*g +: 8]),
            .subst (w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0 = w_prev[127:96] ^ w_t;
    assign w_n1 = w_prev[95:64]  ^ w_n0;
    assign w_n2 = w_prev[63:32]  ^ w_n1;
    assign w_n3 = w_prev[31:0]   ^ w_n2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:   if (bus.start_i)      w_state_next = c_expand;
            c_expand: if (r_rnd == c_last)  w_state_next = c_idle;
            default:                        w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rnd   <= 4'd0;
            r_rcon  <= 8'h01;
            r_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_accept) begin
            r_bank[0] <= bus.key_i;
            r_rnd     <= 4'd1;
            r_rcon    <= 8'h01;
            r_ready   <= 1'b0;
        end else if (r_state == c_expand) begin
            r_bank[r_rnd] <= {w_n0, w_n1, w_n2, w_n3};
            r_rnd         <= r_rnd + 4'd1;
            r_rcon        <= xtime(r_rcon);
            if (r_rnd == c_last) begin
                r_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.busy_o      = (r_state == c_expand);
        bus.key_ready_o = r_ready;
        bus.r_con_o     = (r_state == c_expand) ? r_rcon : 8'h00;
        bus.round_key_o = (bus.rd_idx_i <= c_last) ? r_bank[bus.rd_idx_i] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand
// Purpose  : Directed self-checking bench for the AES-128 key expander.
// Revision : 1.0
// ============================================================================
module tb_aes_key_expand;

    logic clk;
    logic nrst;
    int   vectors;
    int   miscompares;

    localparam logic [127:0] c_key_a1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_a1_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_a1_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_z_r1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] c_z_r10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic read_key(input logic [3:0] idx, input string tag,
                            input logic [127:0] expected);
        bus.rd_idx_i = idx;
        #1;
        check(tag, bus.round_key_o, expected);
    endtask

    // Starts at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_key(input logic [127:0] key);
        bus.start_i = 1'b1;
        bus.key_i   = key;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst        = 1'b0;
        bus.start_i = 1'b0;
        bus.key_i   = '0;
        bus.rd_idx_i = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  {127'b0, bus.busy_o},      128'd0);
        check("reset_ready", {127'b0, bus.key_ready_o}, 128'd0);
        check("reset_rcon",  {120'b0, bus.r_con_o},     128'd0);
        for (int i = 0; i < 16; i++) begin
            read_key(4'(i), "reset_bank", 128'd0);
        end
        nrst = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 with an ignored second start four cycles in.
        start_key(c_key_a1);
        for (int i = 0; i < 10; i++) begin
            check("a1_busy",  {127'b0, bus.busy_o},      128'd1);
            check("a1_ready", {127'b0, bus.key_ready_o}, 128'd0);
            check("a1_rcon",  {120'b0, bus.r_con_o},     {120'b0, rcon_exp[i]});
            if (i == 3) begin
                bus.start_i = 1'b1;
                bus.key_i   = '0;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        check("a1_done_busy",  {127'b0, bus.busy_o},      128'd0);
        check("a1_done_ready", {127'b0, bus.key_ready_o}, 128'd1);
        check("a1_done_rcon",  {120'b0, bus.r_con_o},     128'd0);
        read_key(4'd1,  "a1_rk1",  c_a1_r1);
        read_key(4'd10, "a1_rk10", c_a1_r10);
        read_key(4'd0,  "a1_rk0",  c_key_a1);
        read_key(4'd11, "oob_11",  128'd0);
        read_key(4'd15, "oob_15",  128'd0);

        // Restart with an all-zero key right after ready.
        @(negedge clk);
        start_key(128'd0);
        for (int i = 0; i < 10; i++) begin
            check("zero_ready", {127'b0, bus.key_ready_o}, 128'd0);
            check("zero_busy",  {127'b0, bus.busy_o},      128'd1);
            @(negedge clk);
        end
        check("zero_done_ready", {127'b0, bus.key_ready_o}, 128'd1);
        read_key(4'd0,  "zero_rk0",  128'd0);
        read_key(4'd1,  "zero_rk1",  c_z_r1);
        read_key(4'd10, "zero_rk10", c_z_r10);

        // Reset pulse in cycle five of a run.
        start_key(c_key_a1);
        repeat (4) @(negedge clk);
        check("mid_busy_pre", {127'b0, bus.busy_o}, 128'd1);
        nrst = 1'b0;
        #1;
        check("mid_busy",  {127'b0, bus.busy_o},      128'd0);
        check("mid_ready", {127'b0, bus.key_ready_o}, 128'd0);
        check("mid_rcon",  {120'b0, bus.r_con_o},     128'd0);
        read_key(4'd0,  "mid_rk0",  128'd0);
        read_key(4'd10, "mid_rk10", 128'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_busy",  {127'b0, bus.busy_o},      128'd0);
        check("post_ready", {127'b0, bus.key_ready_o}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
